// File: rtl/param_page_sequencer.sv
// Two-requester page loader: grants one requester round-robin, writes its value
// to a PIO register, reads it back and retries a bounded number of times.
module param_page_sequencer #(
  parameter int         MAX_RETRY = 2,
  parameter logic [1:0] PIO_ADDR  = 2'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_a,
  input  logic [15:0] page_a,
  output logic        done_a,
  output logic        fail_a,
  input  logic        req_b,
  input  logic [15:0] page_b,
  output logic        done_b,
  output logic        fail_b,
  output logic [1:0]  pio_address,
  output logic        pio_chipselect,
  output logic        pio_write_n,
  output logic [31:0] pio_writedata,
  input  logic [31:0] pio_readdata,
  output logic        busy,
  output logic        owner,
  output logic [15:0] cur_page
);

  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4,
    FAIL  = 3'd5
  } state_t;

  state_t        state_r;
  logic [15:0]   page_r;
  logic [31:0]   rd_r;
  logic [RW-1:0] retry_r;
  logic          grant_b_s;
  logic [15:0]   grant_page_s;

  // The register only holds the low half of the word; the upper half must read back as zero.
  function automatic logic readback_ok(input logic [31:0] rd, input logic [15:0] pg);
    return rd == {16'h0000, pg};
  endfunction

  // Round-robin pick: on a tie the requester not served last wins.
  always_comb begin
    grant_b_s    = 1'b0;
    grant_page_s = page_a;
    if (req_b && (!req_a || !owner)) begin
      grant_b_s    = 1'b1;
      grant_page_s = page_b;
    end else begin
      grant_b_s    = 1'b0;
      grant_page_s = page_a;
    end
  end

  // Address is fixed for every access.
  assign pio_address = PIO_ADDR;

  // Sequencer state and all registered outputs; strobes are set for the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r        <= IDLE;
      page_r         <= 16'h0000;
      rd_r           <= 32'h0000_0000;
      retry_r        <= '0;
      owner          <= 1'b1;
      busy           <= 1'b0;
      cur_page       <= 16'h0000;
      done_a         <= 1'b0;
      done_b         <= 1'b0;
      fail_a         <= 1'b0;
      fail_b         <= 1'b0;
      pio_chipselect <= 1'b0;
      pio_write_n    <= 1'b1;
      pio_writedata  <= 32'h0000_0000;
    end else begin
      done_a         <= 1'b0;
      done_b         <= 1'b0;
      fail_a         <= 1'b0;
      fail_b         <= 1'b0;
      pio_chipselect <= 1'b0;
      pio_write_n    <= 1'b1;
      pio_writedata  <= 32'h0000_0000;
      case (state_r)
        IDLE: begin
          if (req_a || req_b) begin
            owner          <= grant_b_s;
            page_r         <= grant_page_s;
            retry_r        <= '0;
            state_r        <= WRITE;
            busy           <= 1'b1;
            pio_chipselect <= 1'b1;
            pio_write_n    <= 1'b0;
            pio_writedata  <= {16'h0000, grant_page_s};
          end else begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end
        end
        WRITE: begin
          state_r        <= READ;
          busy           <= 1'b1;
          pio_chipselect <= 1'b1;
          pio_write_n    <= 1'b1;
        end
        READ: begin
          rd_r    <= pio_readdata;
          state_r <= CHECK;
          busy    <= 1'b1;
        end
        CHECK: begin
          busy <= 1'b1;
          if (readback_ok(rd_r, page_r)) begin
            state_r  <= DONE;
            cur_page <= page_r;
            done_a   <= ~owner;
            done_b   <= owner;
          end else if (retry_r < RETRY_LIMIT) begin
            retry_r        <= retry_r + RW'(1);
            state_r        <= WRITE;
            pio_chipselect <= 1'b1;
            pio_write_n    <= 1'b0;
            pio_writedata  <= {16'h0000, page_r};
          end else begin
            state_r <= FAIL;
            fail_a  <= ~owner;
            fail_b  <= owner;
          end
        end
        DONE: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
        FAIL: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_param_page_sequencer.sv
// Randomized bench for param_page_sequencer: a transaction-level model predicts
// winner, write count, pulse timing and cur_page from the arbitration and retry rules.
module tb_param_page_sequencer;

  localparam int         MAX_RETRY = 2;
  localparam logic [1:0] PIO_ADDR  = 2'd0;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_a, req_b;
  logic [15:0] page_a, page_b;
  logic        done_a, fail_a, done_b, fail_b;
  logic [1:0]  pio_address;
  logic        pio_chipselect, pio_write_n;
  logic [31:0] pio_writedata, pio_readdata;
  logic        busy, owner;
  logic [15:0] cur_page;

  int n_cmp = 0;
  int n_mis = 0;

  // PIO slave: echoes the last write; readbacks before corrupt_until are damaged.
  logic [31:0] mem = 32'h0000_0000;
  int          read_idx = 0;
  int          corrupt_until = 0;
  bit          bad_mode = 1'b0;

  // Model state
  logic        last_owner;
  logic [15:0] exp_cur;

  param_page_sequencer #(.MAX_RETRY(MAX_RETRY), .PIO_ADDR(PIO_ADDR)) dut (
    .clk(clk), .reset(reset),
    .req_a(req_a), .page_a(page_a), .done_a(done_a), .fail_a(fail_a),
    .req_b(req_b), .page_b(page_b), .done_b(done_b), .fail_b(fail_b),
    .pio_address(pio_address), .pio_chipselect(pio_chipselect),
    .pio_write_n(pio_write_n), .pio_writedata(pio_writedata),
    .pio_readdata(pio_readdata), .busy(busy), .owner(owner), .cur_page(cur_page)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pio_chipselect && !pio_write_n) mem <= pio_writedata;
    if (pio_chipselect && pio_write_n) read_idx <= read_idx + 1;
  end

  assign pio_readdata = bad_mode ? 32'hFFFF_0000 :
                        (read_idx < corrupt_until) ? (mem ^ 32'h0000_0100) : mem;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // One transaction from the IDLE negedge through the IDLE cycle after its pulse.
  task automatic run_txn(input logic ra, input logic rb, input logic [15:0] pa,
                         input logic [15:0] pb, input int corrupt, input bit always_bad,
                         input bit hold);
    logic        winner;
    logic [15:0] ep;
    bit          ok;
    int          attempts, k_end, writes;
    winner   = (ra && rb) ? ~last_owner : rb;
    ep       = winner ? pb : pa;
    ok       = !always_bad && (corrupt <= MAX_RETRY);
    attempts = ok ? corrupt + 1 : MAX_RETRY + 1;
    k_end    = ok ? 4 + 3 * corrupt : 3 * (MAX_RETRY + 1) + 1;
    writes   = 0;
    corrupt_until = read_idx + corrupt;
    bad_mode = always_bad;
    req_a = ra; req_b = rb; page_a = pa; page_b = pb;
    for (int k = 1; k <= k_end + 1; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check_val("owner", 32'(owner), 32'(winner));
        check_val("busy_on", 32'(busy), 32'd1);
        page_a = 16'($urandom);
        page_b = 16'($urandom);
        if (!hold) begin
          req_a = 1'b0;
          req_b = 1'b0;
        end
      end
      if (pio_chipselect && !pio_write_n) begin
        writes++;
        check_val("wdata", pio_writedata, {16'h0000, ep});
        check_val("addr", 32'(pio_address), 32'(PIO_ADDR));
      end
      if (k == k_end) begin
        check_val("done_a", 32'(done_a), 32'(ok && !winner));
        check_val("done_b", 32'(done_b), 32'(ok && winner));
        check_val("fail_a", 32'(fail_a), 32'(!ok && !winner));
        check_val("fail_b", 32'(fail_b), 32'(!ok && winner));
      end else begin
        check_val("no_pulse", 32'({done_a, done_b, fail_a, fail_b}), 32'd0);
      end
    end
    if (ok) exp_cur = ep;
    last_owner = winner;
    check_val("busy_off", 32'(busy), 32'd0);
    check_val("cur_page", 32'(cur_page), 32'(exp_cur));
    check_val("writes", 32'(writes), 32'(attempts));
  endtask

  // Reset landing while the sequencer is in READ.
  task automatic reset_mid_read();
    bad_mode = 1'b0;
    corrupt_until = read_idx;
    req_a = 1'b1; req_b = 1'b0; page_a = 16'($urandom);
    @(negedge clk);
    @(negedge clk);
    check_val("in_read_cs", 32'(pio_chipselect), 32'd1);
    #2 reset = 1'b1;
    #1;
    check_val("rst_cs", 32'(pio_chipselect), 32'd0);
    check_val("rst_wn", 32'(pio_write_n), 32'd1);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_owner", 32'(owner), 32'd1);
    check_val("rst_cur", 32'(cur_page), 32'd0);
    req_a = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_val("rst_pulses", 32'({done_a, done_b, fail_a, fail_b}), 32'd0);
    end
    reset = 1'b0;
    last_owner = 1'b1;
    exp_cur = 16'h0000;
  endtask

  initial begin
    bit   ra, rb, hb, bad;
    int   r, c;
    reset = 1'b1;
    req_a = 1'b0; req_b = 1'b0; page_a = 16'h0000; page_b = 16'h0000;
    last_owner = 1'b1;
    exp_cur = 16'h0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_busy0", 32'(busy), 32'd0);
    check_val("rst_owner0", 32'(owner), 32'd1);
    check_val("rst_cur0", 32'(cur_page), 32'd0);
    check_val("rst_strobes0", 32'({pio_chipselect, pio_write_n}), 32'd1);
    check_val("rst_wdata0", pio_writedata, 32'd0);
    check_val("rst_pulses0", 32'({done_a, done_b, fail_a, fail_b}), 32'd0);
    reset = 1'b0;

    // Both held: A, B, A in turn.
    run_txn(1'b1, 1'b1, 16'h0011, 16'h0022, 0, 1'b0, 1'b1);
    run_txn(1'b1, 1'b1, 16'h0011, 16'h0022, 0, 1'b0, 1'b1);
    run_txn(1'b1, 1'b1, 16'h0011, 16'h0022, 0, 1'b0, 1'b0);
    run_txn(1'b1, 1'b0, 16'h1234, 16'h0000, 0, 1'b0, 1'b0);
    run_txn(1'b1, 1'b0, 16'hBEEF, 16'h0000, 1, 1'b0, 1'b0);
    run_txn(1'b0, 1'b1, 16'h0000, 16'h5A5A, 0, 1'b1, 1'b0);
    run_txn(1'b0, 1'b1, 16'h0000, 16'h0F0F, 3, 1'b0, 1'b0);
    run_txn(1'b1, 1'b1, 16'hAAAA, 16'h5555, 2, 1'b0, 1'b0);

    reset_mid_read();
    run_txn(1'b1, 1'b0, 16'h4321, 16'h0000, 0, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      ra = 1'($urandom);
      rb = 1'($urandom);
      if (!ra && !rb) ra = 1'b1;
      r = int'($urandom_range(0, 7));
      c = (r <= 4) ? 0 : r - 4;
      bad = ($urandom_range(0, 9) == 0);
      hb = 1'($urandom);
      run_txn(ra, rb, 16'($urandom), 16'($urandom), c, bad, hb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/param_page_sequencer.md
PARAM_PAGE_SEQUENCER -- requirements
Module: param_page_sequencer

Interface
REQ-001 SHALL provide parameter MAX_RETRY, default 2: number of rewrite attempts after a readback mismatch.
REQ-002 SHALL provide parameter PIO_ADDR, default 2'd0: PIO register address driven on every access.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 req_a  in  1  requester A asks to load a page/length value.
REQ-006 page_a  in  16  requester A value; stable while req_a high.
REQ-007 done_a  out  1  one-cycle pulse: A's value written and verified.
REQ-008 fail_a  out  1  one-cycle pulse: A's value failed verification after all retries.
REQ-009 req_b, page_b, done_b, fail_b SHALL mirror REQ-005..008 for requester B.
REQ-010 pio_address  out  2  PIO slave address.
REQ-011 pio_chipselect  out  1  PIO chip select.
REQ-012 pio_write_n  out  1  PIO write strobe, active-low.
REQ-013 pio_writedata  out  32  PIO write data.
REQ-014 pio_readdata  in  32  PIO read data; combinational, zero wait states.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 owner  out  1  requester of current or last transaction (0=A, 1=B).
REQ-017 cur_page  out  16  last successfully verified value.

Function
REQ-018 FSM states SHALL be IDLE, WRITE, READ, CHECK, DONE, FAIL; one cycle per state except IDLE.
REQ-019 In IDLE with any req high, the FSM SHALL grant one requester, latch its page into page_q, clear retry_cnt, set owner, and go to WRITE.
REQ-020 Arbitration SHALL be round-robin: with both requests high, grant the requester not granted last; after reset, A wins the first tie.
REQ-021 WRITE SHALL drive chipselect=1, write_n=0, address=PIO_ADDR, writedata={16'h0000,page_q}, then go to READ.
REQ-022 READ SHALL drive chipselect=1, write_n=1, address=PIO_ADDR, capture pio_readdata into rd_q at cycle end, then go to CHECK.
REQ-023 Outside WRITE/READ: chipselect=0, write_n=1, writedata=0, address=PIO_ADDR.
REQ-024 CHECK SHALL match when rd_q=={16'h0000,page_q}; match -> DONE.
REQ-025 On mismatch with retry_cnt<MAX_RETRY: retry_cnt+1, go to WRITE; else go to FAIL.
REQ-026 DONE SHALL assert done of the owner for that one cycle, load cur_page<=page_q, then go to IDLE.
REQ-027 FAIL SHALL assert fail of the owner for that one cycle, leave cur_page unchanged, then go to IDLE.
REQ-028 Fault-free latency: grant edge to done pulse = 4 cycles (WRITE, READ, CHECK, DONE); each retry adds 3 cycles.
REQ-029 Requests are ignored outside IDLE; page inputs are sampled only at the grant edge.
REQ-030 A req still high in IDLE after its done/fail SHALL be a new request, arbitrated per REQ-020.
REQ-031 done_x and fail_x SHALL never assert together, and never for the non-owner.
REQ-032 retry_cnt width SHALL be clog2(MAX_RETRY+1), minimum 1 bit; MAX_RETRY=0 means no retry.

Reset
REQ-033 While reset is high: state=IDLE, all done/fail=0, busy=0, owner=1 (so A wins the first tie), cur_page=0, page_q=0, rd_q=0, retry_cnt=0, pio_chipselect=0, pio_write_n=1, pio_writedata=0.
REQ-034 Reset mid-transaction SHALL abandon the transaction with no done/fail pulse and cur_page=0; PIO strobes deassert asynchronously.

Verification
REQ-035 PIO model echoes writes; req_a=1, page_a=16'h1234 -> WRITE with writedata 32'h00001234, done_a 4 cycles after grant, cur_page=16'h1234, owner=0.
REQ-036 req_a and req_b both high from reset, pages 16'h0011/16'h0022 held -> A then B then A served; each done only to its owner; cur_page tracks the order.
REQ-037 PIO corrupts the first readback only -> one retry, done_a 7 cycles after grant, fail_a never high.
REQ-038 PIO always returns 32'hFFFF0000 -> MAX_RETRY+1=3 writes, fail_b pulse, cur_page unchanged, FSM back in IDLE.
REQ-039 Reset asserted during READ -> strobes low immediately, no done/fail, cur_page=0; a request after reset is released completes normally.
REQ-040 page_a changed while busy -> writedata keeps the value latched at grant.
